// File: rtl/data_inf_intc_m2s_wrr_sched.sv
// Weighted round-robin scheduler sharing one data_inf master channel between NUM streams.
// Each owner may hold the channel for up to its weight in beats; arbitration costs one bubble.
module data_inf_intc_m2s_wrr_sched #(
  parameter int NUM    = 4,
  parameter int DSIZE  = 32,
  parameter int IDSIZE = 4,
  parameter int WSIZE  = 4,
  parameter int NSIZE  = $clog2(NUM)
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [NUM-1:0]          s_valid,
  input  logic [NUM*DSIZE-1:0]    s_data,
  input  logic [NUM*IDSIZE-1:0]   sid,
  output logic [NUM-1:0]          s_ready,
  input  logic [NUM*WSIZE-1:0]    weight,
  output logic                    m_valid,
  output logic [DSIZE-1:0]        m_data,
  output logic [IDSIZE-1:0]       mid,
  input  logic                    m_ready,
  output logic [NSIZE-1:0]        grant_idx,
  output logic                    busy
);

  localparam logic [NSIZE:0] NUM_W = (NSIZE+1)'(NUM);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state, w_stateNext;
  logic [NSIZE-1:0] r_rrPtr, w_rrPtrNext;
  logic [NSIZE-1:0] r_grantIdx, w_grantIdxNext;
  logic [WSIZE-1:0] r_beatCnt, w_beatCntNext;
  logic [WSIZE-1:0] r_wq, w_wqNext;

  logic [NUM-1:0]   w_cand;
  logic [NSIZE:0]   w_probe;
  logic             w_found;
  logic [NSIZE-1:0] w_candIdx;
  logic [WSIZE-1:0] w_candWeight;
  logic [NSIZE:0]   w_releaseSum;
  logic [NSIZE-1:0] w_releasePtr;
  logic             w_beat;

  // Round-robin search: descending probe order so the lowest offset from rr_ptr wins.
  always_comb begin
    w_cand       = '0;
    w_found      = 1'b0;
    w_candIdx    = '0;
    w_candWeight = '0;
    w_probe      = '0;
    for (int i = 0; i < NUM; i++) begin
      w_cand[i] = s_valid[i] & (|weight[i*WSIZE +: WSIZE]);
    end
    for (int k = NUM-1; k >= 0; k--) begin
      w_probe = {1'b0, r_rrPtr} + (NSIZE+1)'(k);
      if (w_probe >= NUM_W) w_probe = w_probe - NUM_W;
      if (w_cand[w_probe[NSIZE-1:0]]) begin
        w_found   = 1'b1;
        w_candIdx = w_probe[NSIZE-1:0];
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (NSIZE'(i) == w_candIdx) w_candWeight = weight[i*WSIZE +: WSIZE];
    end
    w_releaseSum = {1'b0, r_grantIdx} + (NSIZE+1)'(1);
    w_releasePtr = (w_releaseSum >= NUM_W) ? '0 : w_releaseSum[NSIZE-1:0];
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_grantIdx <= '0;
      r_beatCnt  <= '0;
      r_wq       <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_rrPtr    <= w_rrPtrNext;
      r_grantIdx <= w_grantIdxNext;
      r_beatCnt  <= w_beatCntNext;
      r_wq       <= w_wqNext;
    end
  end

  // Quota exhaustion is tested first; a voluntary release can only happen on a beat-less cycle.
  always_comb begin
    w_stateNext    = r_state;
    w_rrPtrNext    = r_rrPtr;
    w_grantIdxNext = r_grantIdx;
    w_beatCntNext  = r_beatCnt;
    w_wqNext       = r_wq;
    w_beat         = m_valid & m_ready;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext    = GRANT;
          w_grantIdxNext = w_candIdx;
          w_beatCntNext  = '0;
          w_wqNext       = w_candWeight;
        end
      end
      GRANT: begin
        if (w_beat && (r_beatCnt == (r_wq - WSIZE'(1)))) begin
          w_stateNext = IDLE;
          w_rrPtrNext = w_releasePtr;
        end else if (!m_valid) begin
          w_stateNext = IDLE;
          w_rrPtrNext = w_releasePtr;
        end else if (w_beat) begin
          w_beatCntNext = r_beatCnt + WSIZE'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    m_valid   = 1'b0;
    m_data    = '0;
    mid       = '0;
    s_ready   = '0;
    busy      = (r_state == GRANT);
    grant_idx = r_grantIdx;
    if (r_state == GRANT) begin
      for (int i = 0; i < NUM; i++) begin
        if (NSIZE'(i) == r_grantIdx) begin
          m_valid    = s_valid[i];
          m_data     = s_data[i*DSIZE +: DSIZE];
          mid        = sid[i*IDSIZE +: IDSIZE];
          s_ready[i] = m_ready;
        end
      end
    end
  end

endmodule
